// File: rtl/sim_exit_monitor_pkg.sv
// Purpose: shared types and constants for the simulation exit monitor.
//   state_e       : monitor FSM states
//   exit_reason_e : why the test ended (NONE/SUCCESS/TOHOST/TIMEOUT)
//   TIMEOUT_CODE  : exit code reported on a watchdog expiry
package sim_exit_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      EXIT_NONE    = 2'd0,
      EXIT_SUCCESS = 2'd1,
      EXIT_TOHOST  = 2'd2,
      EXIT_TIMEOUT = 2'd3
   } exit_reason_e;

   localparam logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF;

endpackage

// File: rtl/sim_exit_monitor_if.sv
// Purpose: tohost valid/ready handshake between the harness and the monitor.
//   tohost_valid : payload valid (harness -> monitor)
//   tohost_bits  : 64-bit payload (harness -> monitor)
//   tohost_ready : monitor accepts payload (monitor -> harness)
interface sim_exit_monitor_if;
   logic        tohost_valid;
   logic [63:0] tohost_bits;
   logic        tohost_ready;

   modport master (output tohost_valid, output tohost_bits, input  tohost_ready);
   modport slave  (input  tohost_valid, input  tohost_bits, output tohost_ready);
endinterface

// File: rtl/sim_exit_monitor_sat_counter.sv
// Purpose: up-counter that sticks at its all-ones value.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset (clears the count)
//   i_inc   : advance by one when not saturated
//   i_clear : synchronous clear, wins over i_inc
//   o_count : current count
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   input  logic         i_clear,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/sim_exit_monitor.sv
// Purpose: watches the harness for the end of a test (success flag, tohost
// exit payload or watchdog expiry), latches the exit details, waits a drain
// period and then raises done.
//   clock, reset_n : clock and asynchronous active-low reset
//   io_success     : level success flag from the harness
//   tohost         : tohost valid/ready payload channel (slave side)
//   max_cycles     : watchdog limit, 0 disables
//   done, pass     : test finished / passed (pass only meaningful with done)
//   exit_reason    : exit_reason_e of the latched exit
//   exit_code      : latched exit code
//   finish_cycle   : cycle count at the exit event
//   msg_count      : accepted non-exit tohost payloads
//
// state    | meaning
// ST_RUN   | test running, any exit event is taken
// ST_DRAIN | exit latched, counting down drain cycles, exits ignored
// ST_DONE  | terminal until reset, done high, tohost not accepted
module sim_exit_monitor
   import sim_exit_pkg::*;
#(
   parameter int DRAIN_CYCLES = 16,
   parameter int MSG_CNT_W    = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 io_success,
   sim_exit_monitor_if.slave    tohost,
   input  logic [63:0]          max_cycles,
   output logic                 done,
   output logic                 pass,
   output logic [1:0]           exit_reason,
   output logic [31:0]          exit_code,
   output logic [63:0]          finish_cycle,
   output logic [MSG_CNT_W-1:0] msg_count
);

   localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES - 1);

   state_e       r_state;
   logic [7:0]   r_drain_cnt;
   logic         r_ready;
   logic         r_done;
   logic         r_pass;
   exit_reason_e r_reason;
   logic [31:0]  r_code;
   logic [63:0]  r_finish;

   logic [63:0]  w_cycle_cnt;
   logic         w_hs;
   logic         w_msg;
   logic         w_in_run;
   logic         w_ev_tohost;
   logic         w_ev_success;
   logic         w_ev_timeout;
   logic         w_exit;
   logic [31:0]  w_th_code;

   assign w_hs         = tohost.tohost_valid & r_ready;
   assign w_th_code    = tohost.tohost_bits[32:1];
   // Zero payloads are idle writes from the harness, neither message nor exit.
   assign w_msg        = w_hs & (|tohost.tohost_bits) & ~tohost.tohost_bits[0];
   assign w_in_run     = (r_state == ST_RUN);
   assign w_ev_tohost  = w_in_run & w_hs & tohost.tohost_bits[0];
   assign w_ev_success = w_in_run & io_success;
   assign w_ev_timeout = w_in_run & (max_cycles != 64'd0) & (w_cycle_cnt == max_cycles);
   assign w_exit       = w_ev_tohost | w_ev_success | w_ev_timeout;

   sat_counter #(.W(64)) u_cycle_cnt (
      .i_clk   (clock),
      .i_rst_n (reset_n),
      .i_inc   (1'b1),
      .i_clear (1'b0),
      .o_count (w_cycle_cnt)
   );

   sat_counter #(.W(MSG_CNT_W)) u_msg_cnt (
      .i_clk   (clock),
      .i_rst_n (reset_n),
      .i_inc   (w_msg),
      .i_clear (1'b0),
      .o_count (msg_count)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_RUN;
         r_drain_cnt <= 8'd0;
         r_ready     <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_reason    <= EXIT_NONE;
         r_code      <= 32'd0;
         r_finish    <= 64'd0;
      end else begin
         case (r_state)
            ST_RUN: begin
               r_ready <= 1'b1;
               if (w_exit) begin
                  r_state     <= ST_DRAIN;
                  r_drain_cnt <= DRAIN_INIT;
                  r_finish    <= w_cycle_cnt;
                  if (w_ev_tohost) begin
                     r_reason <= EXIT_TOHOST;
                     r_code   <= w_th_code;
                     r_pass   <= (w_th_code == 32'd0);
                  end else if (w_ev_success) begin
                     r_reason <= EXIT_SUCCESS;
                     r_code   <= 32'd0;
                     r_pass   <= 1'b1;
                  end else begin
                     r_reason <= EXIT_TIMEOUT;
                     r_code   <= TIMEOUT_CODE;
                     r_pass   <= 1'b0;
                  end
               end
            end
            ST_DRAIN: begin
               if (r_drain_cnt == 8'd0) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_ready <= 1'b0;
               end else begin
                  r_drain_cnt <= r_drain_cnt - 8'd1;
               end
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_ready <= 1'b0;
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign tohost.tohost_ready = r_ready;
   assign done                = r_done;
   // pass is latched at the exit event but only exposed once done is high.
   assign pass                = r_done & r_pass;
   assign exit_reason         = r_reason;
   assign exit_code           = r_code;
   assign finish_cycle        = r_finish;

endmodule

// File: tb/tb_sim_exit_monitor.sv
module tb_sim_exit_monitor;

   localparam int D = 16;

   logic        clock;
   logic        reset_n;
   logic        io_success;
   logic [63:0] max_cycles;
   logic        done;
   logic        pass;
   logic [1:0]  exit_reason;
   logic [31:0] exit_code;
   logic [63:0] finish_cycle;
   logic [31:0] msg_count;

   sim_exit_monitor_if tif ();

   sim_exit_monitor #(.DRAIN_CYCLES(D), .MSG_CNT_W(32)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .io_success   (io_success),
      .tohost       (tif),
      .max_cycles   (max_cycles),
      .done         (done),
      .pass         (pass),
      .exit_reason  (exit_reason),
      .exit_code    (exit_code),
      .finish_cycle (finish_cycle),
      .msg_count    (msg_count)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: the test outcome is a single "first exit" record plus
   // a message tally; outputs follow from arithmetic on the exit cycle.
   longint unsigned m_cyc;
   longint unsigned m_exit_cyc;
   bit              m_exited;
   logic [1:0]      m_reason;
   logic [31:0]     m_code;
   bit              m_pass;
   longint unsigned m_msgs;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout sim time exceeded limit");
      $fatal(1, "timeout");
   end

   function automatic bit exp_done();
      return m_exited && (m_cyc >= m_exit_cyc + 64'(D) + 64'd1);
   endfunction
   function automatic bit exp_ready();
      return (m_cyc >= 64'd1) && !exp_done();
   endfunction
   function automatic logic [1:0]  exp_reason(); return m_exited ? m_reason : 2'd0; endfunction
   function automatic logic [31:0] exp_code();   return m_exited ? m_code : 32'd0; endfunction
   function automatic logic [63:0] exp_finish(); return m_exited ? m_exit_cyc : 64'd0; endfunction
   function automatic bit          exp_pass();   return exp_done() && m_pass; endfunction

   task automatic set_idle();
      tif.tohost_valid = 1'b0;
      tif.tohost_bits  = 64'd0;
      io_success       = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      set_idle();
      repeat (2) @(negedge clock);
      reset_n    = 1'b1;
      m_cyc      = 0;
      m_exit_cyc = 0;
      m_exited   = 0;
      m_reason   = 2'd0;
      m_code     = 32'd0;
      m_pass     = 0;
      m_msgs     = 0;
   endtask

   // Applies the inputs currently driven for cycle m_cyc, advances one clock
   // and returns at the following falling edge.
   task automatic tick();
      bit hs;
      hs = tif.tohost_valid && exp_ready();
      if (!m_exited) begin
         if (hs && tif.tohost_bits[0]) begin
            m_exited = 1; m_reason = 2'd2; m_code = tif.tohost_bits[32:1];
            m_pass = (tif.tohost_bits[32:1] == 32'd0); m_exit_cyc = m_cyc;
         end else if (io_success) begin
            m_exited = 1; m_reason = 2'd1; m_code = 32'd0; m_pass = 1; m_exit_cyc = m_cyc;
         end else if (max_cycles != 64'd0 && m_cyc == max_cycles) begin
            m_exited = 1; m_reason = 2'd3; m_code = 32'hFFFF_FFFF; m_pass = 0; m_exit_cyc = m_cyc;
         end
      end
      if (hs && tif.tohost_bits != 64'd0 && !tif.tohost_bits[0]) m_msgs++;
      @(posedge clock);
      m_cyc++;
      @(negedge clock);
   endtask

   task automatic run_to(input longint unsigned n);
      while (m_cyc < n) tick();
   endtask

   task automatic test_reset();
      max_cycles = 64'd0;
      reset_n = 1'b0;
      set_idle();
      repeat (3) @(negedge clock);
      checks++;
      if (tif.tohost_ready !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || exit_reason !== 2'd0 ||
          exit_code !== 32'd0 || finish_cycle !== 64'd0 || msg_count !== 32'd0) begin
         failures++;
         $display("FAIL reset_values ready=%0b done=%0b pass=%0b reason=%0d code=%h fin=%0d msg=%0d (all must be 0)",
                  tif.tohost_ready, done, pass, exit_reason, exit_code, finish_cycle, msg_count);
      end
      do_reset();
      #1;
      checks++;
      if (tif.tohost_ready !== 1'b0) begin
         failures++; $display("FAIL ready_cycle0 got=%0b exp=0", tif.tohost_ready);
      end
      @(negedge clock);
      tick();
      checks++;
      if (tif.tohost_ready !== 1'b1 || done !== 1'b0) begin
         failures++; $display("FAIL ready_after_reset ready=%0b done=%0b exp ready=1 done=0", tif.tohost_ready, done);
      end
   endtask

   task automatic test_success();
      do_reset();
      run_to(20);
      io_success = 1'b1; tick(); io_success = 1'b0;
      run_to(36);
      checks++;
      if (done !== 1'b0 || pass !== 1'b0) begin
         failures++; $display("FAIL success_early_done done=%0b pass=%0b at cycle 36 exp 0/0", done, pass);
      end
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || exit_reason !== 2'd1 || finish_cycle !== 64'd20 || exit_code !== 32'd0) begin
         failures++;
         $display("FAIL success_exit done=%0b pass=%0b reason=%0d fin=%0d code=%h exp 1/1/1/20/0",
                  done, pass, exit_reason, finish_cycle, exit_code);
      end
   endtask

   task automatic test_tohost_fail();
      do_reset();
      run_to(10);
      tif.tohost_valid = 1'b1; tif.tohost_bits = 64'h7; tick(); set_idle();
      checks++;
      if (exit_code !== 32'd3 || exit_reason !== 2'd2 || finish_cycle !== 64'd10 || pass !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL tohost_latch code=%h reason=%0d fin=%0d pass=%0b done=%0b exp 3/2/10/0/0",
                  exit_code, exit_reason, finish_cycle, pass, done);
      end
      run_to(27);
      checks++;
      if (done !== 1'b1 || pass !== 1'b0) begin
         failures++; $display("FAIL tohost_done done=%0b pass=%0b exp 1/0", done, pass);
      end
   endtask

   task automatic test_watchdog();
      max_cycles = 64'd50;
      do_reset();
      run_to(51);
      checks++;
      if (exit_reason !== 2'd3 || finish_cycle !== 64'd50 || exit_code !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL watchdog_latch reason=%0d fin=%0d code=%h exp 3/50/ffffffff", exit_reason, finish_cycle, exit_code);
      end
      run_to(66);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL watchdog_early done=%0b at 66 exp 0", done); end
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b0) begin
         failures++; $display("FAIL watchdog_done done=%0b pass=%0b at 67 exp 1/0", done, pass);
      end
      max_cycles = 64'd0;
      do_reset();
      run_to(300);
      checks++;
      if (done !== 1'b0 || exit_reason !== 2'd0 || tif.tohost_ready !== 1'b1) begin
         failures++;
         $display("FAIL watchdog_disabled done=%0b reason=%0d ready=%0b exp 0/0/1", done, exit_reason, tif.tohost_ready);
      end
   endtask

   task automatic test_priority();
      do_reset();
      run_to(5);
      tif.tohost_valid = 1'b1; tif.tohost_bits = 64'h1; io_success = 1'b1;
      tick(); set_idle();
      run_to(22);
      checks++;
      if (done !== 1'b1 || exit_reason !== 2'd2 || exit_code !== 32'd0 || pass !== 1'b1) begin
         failures++;
         $display("FAIL priority done=%0b reason=%0d code=%h pass=%0b exp 1/2/0/1", done, exit_reason, exit_code, pass);
      end
   endtask

   task automatic test_messages();
      do_reset();
      run_to(3);
      tif.tohost_valid = 1'b1; tif.tohost_bits = 64'h100; tick();
      tif.tohost_bits = 64'h0; tick();
      tif.tohost_bits = 64'h100; tick();
      set_idle();
      run_to(8);
      io_success = 1'b1; tick(); io_success = 1'b0;
      run_to(10);
      tif.tohost_valid = 1'b1; tif.tohost_bits = 64'h100; tick();
      tif.tohost_bits = 64'h5; io_success = 1'b1; max_cycles = 64'd12; tick();
      set_idle(); max_cycles = 64'd0;
      run_to(25);
      checks++;
      if (msg_count !== 32'd3 || done !== 1'b1 || exit_reason !== 2'd1 || exit_code !== 32'd0 ||
          finish_cycle !== 64'd8 || pass !== 1'b1) begin
         failures++;
         $display("FAIL messages msg=%0d done=%0b reason=%0d code=%h fin=%0d pass=%0b exp 3/1/1/0/8/1",
                  msg_count, done, exit_reason, exit_code, finish_cycle, pass);
      end
      tif.tohost_valid = 1'b1; tif.tohost_bits = 64'h100; tick(); set_idle();
      checks++;
      if (msg_count !== 32'd3 || tif.tohost_ready !== 1'b0 || done !== 1'b1) begin
         failures++;
         $display("FAIL done_terminal msg=%0d ready=%0b done=%0b exp 3/0/1", msg_count, tif.tohost_ready, done);
      end
   endtask

   task automatic test_reset_abort();
      do_reset();
      run_to(12);
      io_success = 1'b1; tick(); io_success = 1'b0;
      run_to(15);
      tif.tohost_valid = 1'b1; tif.tohost_bits = 64'h200; tick(); set_idle();
      run_to(20);
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (tif.tohost_ready !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || exit_reason !== 2'd0 ||
          exit_code !== 32'd0 || finish_cycle !== 64'd0 || msg_count !== 32'd0) begin
         failures++;
         $display("FAIL abort_reset ready=%0b done=%0b pass=%0b reason=%0d code=%h fin=%0d msg=%0d (all must be 0)",
                  tif.tohost_ready, done, pass, exit_reason, exit_code, finish_cycle, msg_count);
      end
      do_reset();
      run_to(30);
      io_success = 1'b1; tick(); io_success = 1'b0;
      run_to(46);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL abort_rerun_early done=%0b at 46 exp 0", done); end
      tick();
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || exit_reason !== 2'd1 || finish_cycle !== 64'd30) begin
         failures++;
         $display("FAIL abort_rerun done=%0b pass=%0b reason=%0d fin=%0d exp 1/1/1/30", done, pass, exit_reason, finish_cycle);
      end
   endtask

   task automatic test_random();
      logic [63:0] b;
      int r;
      for (int it = 0; it < 8; it++) begin
         max_cycles = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(20, 90));
         do_reset();
         for (int c = 0; c < 130; c++) begin
            r = $urandom_range(0, 15);
            b = {$urandom(), $urandom()};
            if (r == 0) b = 64'd0;
            else if (r == 1) begin
               b[0] = 1'b1;
               b[32:1] = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 9));
            end else b[0] = 1'b0;
            tif.tohost_valid = ($urandom_range(0, 1) == 1);
            tif.tohost_bits  = b;
            io_success       = ($urandom_range(0, 39) == 0);
            tick();
            checks++;
            if (done !== exp_done() || pass !== exp_pass() || tif.tohost_ready !== exp_ready()) begin
               failures++;
               $display("FAIL rnd_ctrl it=%0d cyc=%0d done=%0b/%0b pass=%0b/%0b ready=%0b/%0b (got/exp)",
                        it, m_cyc, done, exp_done(), pass, exp_pass(), tif.tohost_ready, exp_ready());
            end
            checks++;
            if (exit_reason !== exp_reason() || exit_code !== exp_code() || finish_cycle !== exp_finish() ||
                msg_count !== 32'(m_msgs)) begin
               failures++;
               $display("FAIL rnd_fields it=%0d cyc=%0d reason=%0d/%0d code=%h/%h fin=%0d/%0d msg=%0d/%0d (got/exp)",
                        it, m_cyc, exit_reason, exp_reason(), exit_code, exp_code(), finish_cycle, exp_finish(),
                        msg_count, m_msgs);
            end
         end
      end
      set_idle();
      max_cycles = 64'd0;
   endtask

   initial begin
      reset_n    = 1'b0;
      max_cycles = 64'd0;
      set_idle();
      test_reset();
      test_success();
      test_tohost_fail();
      test_watchdog();
      test_priority();
      test_messages();
      test_reset_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
